// File: rtl/calc3_seq_pkg.sv
// Shared opcodes, response codes, slot/FSM types and decode helpers for the
// calc3 request sequencer.
package calc3_seq_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SHL   = 4'b0101;
  localparam logic [3:0] OP_SHR   = 4'b0110;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_FETCH = 4'b1010;
  localparam logic [3:0] OP_BR0   = 4'b1100;
  localparam logic [3:0] OP_BR1   = 4'b1101;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;
  localparam logic [1:0] RESP_TMO  = 2'b11;

  typedef enum logic [1:0] {SLOT_FREE, SLOT_ISSUED, SLOT_DONE} slot_state_t;
  typedef enum logic {RUN, BR_WAIT} fsm_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  d1;
    logic [4:0]  d2;
    logic [4:0]  r1;
    logic [31:0] data;
  } cmd_t;

  function automatic logic is_alu(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHL, OP_SHR};
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return op inside {OP_BR0, OP_BR1};
  endfunction

  function automatic logic uses_d1(input logic [3:0] op);
    return is_alu(op) || is_branch(op) || (op == OP_FETCH);
  endfunction

  function automatic logic uses_d2(input logic [3:0] op);
    return is_alu(op) || is_branch(op);
  endfunction

  function automatic logic has_dst(input logic [3:0] op);
    return is_alu(op) || (op == OP_STORE);
  endfunction

  // Stores write the register named by d1; ALU ops write r1.
  function automatic logic [4:0] dst_reg(input cmd_t c);
    return (c.op == OP_STORE) ? c.d1 : c.r1;
  endfunction

endpackage

// File: rtl/calc3_cmd_fifo.sv
// Host command FIFO: power-of-two depth, registered empty/full flags,
// head is visible combinationally from storage.
module calc3_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 51
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + (AW+1)'(1);
    else if (!do_push && do_pop) count_next = count - (AW+1)'(1);
  end

  // NOTE: sequential state is updated only with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  // NOTE: storage has no reset; entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/calc3_req_sequencer.sv
// Command sequencer in front of calc3 port 1: tag allocation, RAW/branch
// blocking, tagged response capture, in-order retire with per-command timeout.
module calc3_req_sequencer
  import calc3_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [4:0]  cmd_d1,
  input  logic [4:0]  cmd_d2,
  input  logic [4:0]  cmd_r1,
  input  logic [31:0] cmd_data,
  output logic [3:0]  req1_cmd,
  output logic [4:0]  req1_d1,
  output logic [4:0]  req1_d2,
  output logic [4:0]  req1_r1,
  output logic [31:0] req1_data,
  output logic [1:0]  req1_tag,
  input  logic [1:0]  out1_resp,
  input  logic [31:0] out1_data,
  input  logic [1:0]  out1_tag,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_resp,
  output logic [31:0] res_data,
  output logic        busy,
  output logic        seq_err
);

  localparam int TMO_W = $clog2(TIMEOUT);

  cmd_t        push_cmd, head;
  logic        fifo_empty, fifo_full, live;
  slot_state_t slot_state   [4];
  logic [1:0]  slot_resp    [4];
  logic [31:0] slot_data    [4];
  logic [4:0]  slot_dst     [4];
  logic        slot_dst_vld [4];
  fsm_t        fsm;
  logic [1:0]  iss_ptr, ret_ptr, br_tag;
  logic [TMO_W-1:0] tmo_cnt;
  logic        hazard, all_free, issue, resp_seen, cap_hit, tmo_limit, tmo_fire, retire;

  // live is low for the first cycle after reset: gates host pushes and stale responses.
  assign push_cmd  = {cmd_op, cmd_d1, cmd_d2, cmd_r1, cmd_data};
  assign cmd_ready = live && !fifo_full;

  calc3_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(cmd_t))) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_valid && cmd_ready && (cmd_op != OP_NOP)),
    .push_data (push_cmd),
    .pop       (issue),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
  always_comb begin
    hazard   = 1'b0;
    all_free = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (slot_state[i] != SLOT_FREE) begin
        all_free = 1'b0;
        if (slot_dst_vld[i] &&
            ((uses_d1(head.op) && head.d1 == slot_dst[i]) ||
             (uses_d2(head.op) && head.d2 == slot_dst[i])))
          hazard = 1'b1;
      end
    end
  end

  assign issue     = !fifo_empty && slot_state[iss_ptr] == SLOT_FREE && fsm == RUN &&
                     !hazard && (!is_branch(head.op) || all_free);
  assign resp_seen = live && (out1_resp != RESP_NONE);
  assign cap_hit   = resp_seen && slot_state[out1_tag] == SLOT_ISSUED;
  assign tmo_limit = slot_state[ret_ptr] == SLOT_ISSUED && tmo_cnt == TMO_W'(TIMEOUT - 1);
  assign tmo_fire  = tmo_limit && !(cap_hit && out1_tag == ret_ptr);
  assign res_valid = slot_state[ret_ptr] == SLOT_DONE;
  assign retire    = res_valid && res_ready;
  assign res_resp  = res_valid ? slot_resp[ret_ptr] : RESP_NONE;
  assign res_data  = res_valid ? slot_data[ret_ptr] : '0;
  assign busy      = !fifo_empty || !all_free;

  // Each slot event requires a distinct prior state, so at most one applies per slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm       <= RUN;
      iss_ptr   <= '0;
      ret_ptr   <= '0;
      br_tag    <= '0;
      tmo_cnt   <= '0;
      seq_err   <= 1'b0;
      live      <= 1'b0;
      req1_cmd  <= OP_NOP;
      req1_d1   <= '0;
      req1_d2   <= '0;
      req1_r1   <= '0;
      req1_data <= '0;
      req1_tag  <= '0;
      for (int i = 0; i < 4; i++) slot_state[i] <= SLOT_FREE;
    end else begin
      live      <= 1'b1;
      req1_cmd  <= OP_NOP;
      req1_d1   <= '0;
      req1_d2   <= '0;
      req1_r1   <= '0;
      req1_data <= '0;
      req1_tag  <= '0;
      if (issue) begin
        req1_cmd            <= head.op;
        req1_d1             <= head.d1;
        req1_d2             <= head.d2;
        req1_r1             <= head.r1;
        req1_data           <= head.data;
        req1_tag            <= iss_ptr;
        slot_state[iss_ptr] <= SLOT_ISSUED;
        iss_ptr             <= iss_ptr + 2'd1;
      end
      if (cap_hit)                slot_state[out1_tag] <= SLOT_DONE;
      if (resp_seen && !cap_hit)  seq_err <= 1'b1;
      if (tmo_fire)               slot_state[ret_ptr] <= SLOT_DONE;
      if (retire) begin
        slot_state[ret_ptr] <= SLOT_FREE;
        ret_ptr             <= ret_ptr + 2'd1;
      end
      tmo_cnt <= (slot_state[ret_ptr] == SLOT_ISSUED && !tmo_limit) ? tmo_cnt + TMO_W'(1) : '0;
      case (fsm)
        RUN: if (issue && is_branch(head.op)) begin
          fsm    <= BR_WAIT;
          br_tag <= iss_ptr;
        end
        BR_WAIT: if (retire && ret_ptr == br_tag) fsm <= RUN;
        default: fsm <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      slot_dst[iss_ptr]     <= dst_reg(head);
      slot_dst_vld[iss_ptr] <= has_dst(head.op);
    end
    if (tmo_fire) begin
      slot_resp[ret_ptr] <= RESP_TMO;
      slot_data[ret_ptr] <= '0;
    end
    if (cap_hit) begin
      slot_resp[out1_tag] <= out1_resp;
      slot_data[out1_tag] <= out1_data;
    end
  end

endmodule

// File: tb/tb_calc3_req_sequencer.sv
// Directed bench for calc3_req_sequencer: the bench plays host and calc3,
// monitors record issues/results at the falling edge for later comparison.
module tb_calc3_req_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [4:0]  cmd_d1 = '0, cmd_d2 = '0, cmd_r1 = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  req1_cmd;
  logic [4:0]  req1_d1, req1_d2, req1_r1;
  logic [31:0] req1_data;
  logic [1:0]  req1_tag;
  logic [1:0]  out1_resp = '0, out1_tag = '0;
  logic [31:0] out1_data = '0;
  logic        res_valid, res_ready = 1'b1;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic        busy, seq_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  tag;
    logic [4:0]  d1;
    logic [31:0] data;
    int          cyc;
  } iss_rec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } res_rec_t;

  iss_rec_t iss_q[$];
  res_rec_t res_q[$];

  calc3_req_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_d1(cmd_d1), .cmd_d2(cmd_d2), .cmd_r1(cmd_r1), .cmd_data(cmd_data),
    .req1_cmd(req1_cmd), .req1_d1(req1_d1), .req1_d2(req1_d2), .req1_r1(req1_r1),
    .req1_data(req1_data), .req1_tag(req1_tag),
    .out1_resp(out1_resp), .out1_data(out1_data), .out1_tag(out1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_resp(res_resp), .res_data(res_data),
    .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (req1_cmd != 4'b0000)
        iss_q.push_back('{op: req1_cmd, tag: req1_tag, d1: req1_d1, data: req1_data, cyc: cyc});
      if (res_valid && res_ready)
        res_q.push_back('{resp: res_resp, data: res_data, cyc: cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    out1_resp = 2'b00;
    res_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    iss_q.delete();
    res_q.delete();
  endtask

  task automatic push(input logic [3:0] op, input logic [4:0] d1, input logic [4:0] d2,
                      input logic [4:0] r1, input logic [31:0] data);
    int k = 0;
    while (!cmd_ready && k < 50) begin
      tick();
      k++;
    end
    if (!cmd_ready) check("push_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_d1 = d1; cmd_d2 = d2; cmd_r1 = r1; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [1:0] tag, input logic [1:0] resp, input logic [31:0] data);
    out1_tag = tag; out1_resp = resp; out1_data = data;
    tick();
    out1_resp = 2'b00;
  endtask

  task automatic wait_issues(input string name, input int n);
    int k = 0;
    while (iss_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    check(name, 64'(iss_q.size()), 64'(n));
  endtask

  task automatic wait_results(input string name, input int n);
    int k = 0;
    while (res_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    check(name, 64'(res_q.size()), 64'(n));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_req1_cmd",  64'(req1_cmd),  64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_seq_err",   64'(seq_err),   64'd0);

    // Independent stores, in-order results
    do_reset();
    push(4'b1001, 5'd1, 5'd0, 5'd0, 32'd10);
    push(4'b1001, 5'd2, 5'd0, 5'd0, 32'd15);
    wait_issues("ind_issues", 2);
    check("ind_tag0",  64'(iss_q[0].tag),  64'd0);
    check("ind_tag1",  64'(iss_q[1].tag),  64'd1);
    check("ind_op0",   64'(iss_q[0].op),   64'h9);
    check("ind_data1", 64'(iss_q[1].data), 64'd15);
    check("ind_busy",  64'(busy),          64'd1);
    respond(2'd0, 2'b01, 32'd10);
    respond(2'd1, 2'b01, 32'd15);
    wait_results("ind_results", 2);
    check("ind_res0", {30'd0, res_q[0].resp, res_q[0].data}, {30'd0, 2'b01, 32'd10});
    check("ind_res1", {30'd0, res_q[1].resp, res_q[1].data}, {30'd0, 2'b01, 32'd15});
    idle(3);
    check("ind_one_cycle_issue", 64'(iss_q.size()), 64'd2);
    check("ind_idle_busy", 64'(busy), 64'd0);

    // RAW hazard chain: store r1, store r2, add r3=r1+r2, fetch r3
    do_reset();
    push(4'b1001, 5'd1, 5'd0, 5'd0, 32'd10);
    push(4'b1001, 5'd2, 5'd0, 5'd0, 32'd15);
    push(4'b0001, 5'd1, 5'd2, 5'd3, 32'd0);
    push(4'b1010, 5'd3, 5'd0, 5'd0, 32'd0);
    wait_issues("raw_stores", 2);
    idle(5);
    check("raw_add_held", 64'(iss_q.size()), 64'd2);
    respond(2'd0, 2'b01, 32'd10);
    respond(2'd1, 2'b01, 32'd15);
    wait_issues("raw_add_issue", 3);
    check("raw_add_op",  64'(iss_q[2].op),  64'h1);
    check("raw_add_tag", 64'(iss_q[2].tag), 64'd2);
    idle(5);
    check("raw_fetch_held", 64'(iss_q.size()), 64'd3);
    respond(2'd2, 2'b01, 32'd25);
    wait_results("raw_add_result", 3);
    wait_issues("raw_fetch_issue", 4);
    check("raw_fetch_after_retire", 64'(iss_q[3].cyc > res_q[2].cyc), 64'd1);
    check("raw_fetch_tag", 64'(iss_q[3].tag), 64'd3);
    respond(2'd3, 2'b01, 32'd25);
    wait_results("raw_fetch_result", 4);
    check("raw_fetch_res", {30'd0, res_q[3].resp, res_q[3].data}, {30'd0, 2'b01, 32'd25});

    // Out-of-order responses, in-order delivery, 5th waits for tag 0
    do_reset();
    for (int i = 0; i < 5; i++) push(4'b0001, 5'd20, 5'd21, 5'(i + 1), 32'd0);
    wait_issues("ooo_four", 4);
    for (int i = 0; i < 4; i++) check("ooo_tag", 64'(iss_q[i].tag), 64'(i));
    idle(5);
    check("ooo_fifth_held", 64'(iss_q.size()), 64'd4);
    respond(2'd2, 2'b01, 32'd102);
    respond(2'd0, 2'b10, 32'd100);
    respond(2'd3, 2'b01, 32'd103);
    respond(2'd1, 2'b01, 32'd101);
    wait_results("ooo_results", 4);
    check("ooo_res0", {30'd0, res_q[0].resp, res_q[0].data}, {30'd0, 2'b10, 32'd100});
    check("ooo_res1", {30'd0, res_q[1].resp, res_q[1].data}, {30'd0, 2'b01, 32'd101});
    check("ooo_res2", {30'd0, res_q[2].resp, res_q[2].data}, {30'd0, 2'b01, 32'd102});
    check("ooo_res3", {30'd0, res_q[3].resp, res_q[3].data}, {30'd0, 2'b01, 32'd103});
    wait_issues("ooo_fifth", 5);
    check("ooo_fifth_tag", 64'(iss_q[4].tag), 64'd0);
    check("ooo_fifth_after_retire", 64'(iss_q[4].cyc > res_q[0].cyc), 64'd1);

    // Timeout: exactly 64 cycles after issue, late response flags seq_err
    do_reset();
    push(4'b0001, 5'd1, 5'd2, 5'd3, 32'd0);
    wait_issues("tmo_issue", 1);
    wait_results("tmo_result", 1);
    check("tmo_latency", 64'(res_q[0].cyc - iss_q[0].cyc), 64'd64);
    check("tmo_res", {30'd0, res_q[0].resp, res_q[0].data}, {30'd0, 2'b11, 32'd0});
    check("tmo_no_err_yet", 64'(seq_err), 64'd0);
    respond(2'd0, 2'b01, 32'd77);
    check("tmo_late_seq_err", 64'(seq_err), 64'd1);
    idle(3);
    check("tmo_no_extra_result", 64'(res_q.size()), 64'd1);

    // Backpressure: held result stays stable, FIFO fills behind a hazard
    do_reset();
    res_ready = 1'b0;
    push(4'b1001, 5'd1, 5'd0, 5'd0, 32'd7);
    wait_issues("bp_issue", 1);
    respond(2'd0, 2'b01, 32'd7);
    for (int i = 0; i < 4; i++) push(4'b1010, 5'd1, 5'd0, 5'd0, 32'd0);
    check("bp_cmd_ready_full", 64'(cmd_ready), 64'd1 - 64'd1 + 64'(1'b0));
    for (int i = 0; i < 10; i++) begin
      check("bp_res_stable", {29'd0, res_valid, res_resp, res_data}, {29'd0, 1'b1, 2'b01, 32'd7});
      tick();
    end
    check("bp_no_handshake", 64'(res_q.size()), 64'd0);
    check("bp_no_issue", 64'(iss_q.size()), 64'd1);

    // Branch: waits for all slots free, blocks issue until it retires
    do_reset();
    push(4'b1001, 5'd4, 5'd0, 5'd0, 32'd1);
    push(4'b1100, 5'd5, 5'd6, 5'd0, 32'd0);
    push(4'b1001, 5'd7, 5'd0, 5'd0, 32'd2);
    wait_issues("br_store", 1);
    idle(5);
    check("br_waits_free", 64'(iss_q.size()), 64'd1);
    respond(2'd0, 2'b01, 32'd1);
    wait_results("br_store_ret", 1);
    wait_issues("br_issue", 2);
    check("br_op",  64'(iss_q[1].op),  64'hc);
    check("br_tag", 64'(iss_q[1].tag), 64'd1);
    check("br_after_free", 64'(iss_q[1].cyc > res_q[0].cyc), 64'd1);
    idle(5);
    check("br_blocks", 64'(iss_q.size()), 64'd2);
    respond(2'd1, 2'b01, 32'd0);
    wait_results("br_ret", 2);
    wait_issues("br_resume", 3);
    check("br_resume_tag", 64'(iss_q[2].tag), 64'd2);
    check("br_resume_after", 64'(iss_q[2].cyc > res_q[1].cyc), 64'd1);

    // Reset mid-operation with three tags outstanding
    do_reset();
    for (int i = 0; i < 3; i++) push(4'b0010, 5'd20, 5'd21, 5'(i + 8), 32'd0);
    wait_issues("mid_three", 3);
    check("mid_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    tick();
    check("mid_outputs_zero",
          {cmd_ready, req1_cmd, res_valid, res_resp, busy, seq_err, res_data},
          {1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0});
    reset_n = 1'b1;
    iss_q.delete();
    res_q.delete();
    respond(2'd0, 2'b01, 32'd5);
    check("mid_first_cycle_ignored", 64'(seq_err), 64'd0);
    respond(2'd1, 2'b01, 32'd6);
    check("mid_stale_seq_err", 64'(seq_err), 64'd1);
    idle(5);
    check("mid_no_results", 64'(res_q.size()), 64'd0);
    check("mid_res_valid", 64'(res_valid), 64'd0);
    check("mid_idle_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
